// File: rtl/mac_operand_driver_pkg.sv
// Shared definitions for the MAC operand driver: FSM state encodings and
// default operand/result widths.
package mac_operand_driver_pkg;

    // Default widths matching the MAC datapath (A/B operands, accumulated out)
    localparam int DEF_DATA_W = 4;
    localparam int DEF_RES_W  = 12;

    // Handshake sequencer states, fixed 3-bit encodings
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_HOLD   = 3'd3,
        ST_GAP    = 3'd4
    } drv_state_t;

endpackage

// File: rtl/mac_operand_driver_fifo.sv
// Small synchronous FIFO holding operand pairs ahead of the MAC launcher.
// DEPTH must be a power of two so the pointers wrap naturally.
// Push while full is honoured only when a pop happens in the same cycle.
module mac_operand_driver_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head of queue is visible without a read cycle so IDLE can latch it directly
    assign rdata = mem[rd_ptr_reg];

    // Storage write; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy tracking; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mac_operand_driver.sv
// Initiator side of the MAC go/done handshake. Buffers host operand pairs,
// launches one MAC operation per pair, waits for done and hands the result
// back over a valid/ready channel. Only one operation is ever in flight.
// Optional feature macro: MAC_DRV_TIMEOUT_EN adds a done watchdog that
// returns a zero result and raises a sticky timeout flag.
module mac_operand_driver
    import mac_operand_driver_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RES_W       = DEF_RES_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              in_ready,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    output logic              mac_go,
    input  logic [RES_W-1:0]  mac_out,
    input  logic              mac_done,
    output logic              res_valid,
    output logic [RES_W-1:0]  res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              timeout
);

    localparam int PAIR_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    drv_state_t        state_reg;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              wait_expired;

    // Ready comes from the registered count only, never from this cycle's pop
    assign in_ready  = ~fifo_full;
    assign fifo_push = in_valid & ~fifo_full;
    assign fifo_pop  = (state_reg == ST_IDLE) & ~fifo_empty;
    assign busy      = (state_reg != ST_IDLE) | (fifo_count != '0);

    mac_operand_driver_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef MAC_DRV_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] wait_cnt_reg;
    logic             timeout_reg;

    // Fires on the last permitted WAIT cycle if done has still not arrived
    assign wait_expired = (state_reg == ST_WAIT) & ~mac_done &
                          (wait_cnt_reg == TMO_W'(TIMEOUT_CYC - 1));
    assign timeout      = timeout_reg;

    // Counts WAIT cycles of the current operation; cleared in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ST_WAIT) && !mac_done) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Sticky watchdog flag, only cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_reg <= 1'b0;
        end else if (wait_expired) begin
            timeout_reg <= 1'b1;
        end
    end
`else
    // Without the watchdog WAIT lasts until done, however long that takes
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;

    // The timeout setting is meaningless here; a degenerate value changes nothing
    if (TIMEOUT_CYC < 1) begin : g_timeout_unused
    end
`endif

    // Handshake sequencer with registered MAC and host-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            mac_a     <= '0;
            mac_b     <= '0;
            mac_go    <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        mac_a     <= fifo_head[PAIR_W-1:DATA_W];
                        mac_b     <= fifo_head[DATA_W-1:0];
                        mac_go    <= 1'b1;
                        state_reg <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    mac_go    <= 1'b0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mac_done) begin
                        res_data  <= mac_out;
                        res_valid <= 1'b1;
                        state_reg <= ST_HOLD;
                    end else if (wait_expired) begin
                        res_data  <= '0;
                        res_valid <= 1'b1;
                        state_reg <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // Quiet cycle so the MAC can drop done before the next go
                    state_reg <= ST_IDLE;
                end
                default: begin
                    mac_go    <= 1'b0;
                    res_valid <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_driver.sv
// Bench for mac_operand_driver. A behavioural MAC stub answers each go with
// done after a programmable latency; its result is A*B + 0x800 so the top
// result bit is exercised. Stub done stays high until the next go.
module tb_mac_operand_driver;

    localparam int DW = 4;
    localparam int RW = 12;
    localparam int DEPTH = 4;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          in_ready;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic          mac_go;
    logic [RW-1:0] mac_out;
    logic          mac_done;
    logic          res_valid;
    logic [RW-1:0] res_data;
    logic          res_ready;
    logic          busy;
    logic          timeout;

    always #5 clk = ~clk;

    mac_operand_driver #(
        .DATA_W(DW), .RES_W(RW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
        .mac_a(mac_a), .mac_b(mac_b), .mac_go(mac_go),
        .mac_out(mac_out), .mac_done(mac_done),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy), .timeout(timeout)
    );

    // MAC stub
    int stub_lat = 1;
    bit stub_never = 1'b0;
    int stub_cnt;
    bit stub_run;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mac_done <= 1'b0;
            mac_out  <= '0;
            stub_run <= 1'b0;
            stub_cnt <= 0;
        end else if (mac_go) begin
            mac_done <= 1'b0;
            stub_run <= 1'b1;
            stub_cnt <= stub_lat;
        end else if (stub_run && !stub_never) begin
            if (stub_cnt <= 1) begin
                mac_done <= 1'b1;
                mac_out  <= RW'(mac_a) * RW'(mac_b) + 12'h800;
                stub_run <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // Monitors: go pulse count/width, operand stability while in flight
    int go_cnt = 0;
    int go_wide = 0;
    int stab_err = 0;
    bit prev_go = 1'b0;
    bit inflight = 1'b0;
    logic [DW-1:0] cap_a, cap_b;
    always @(posedge clk) begin
        prev_go <= mac_go;
        if (mac_go) go_cnt <= go_cnt + 1;
        if (mac_go && prev_go) go_wide <= go_wide + 1;
        if (rst) begin
            inflight <= 1'b0;
        end else if (mac_go) begin
            cap_a <= mac_a;
            cap_b <= mac_b;
            inflight <= 1'b1;
        end else if (inflight) begin
            if (mac_a != cap_a || mac_b != cap_b) stab_err <= stab_err + 1;
            if (mac_done) inflight <= 1'b0;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        $display("push a=%0d b=%0d at %0t", a, b, $time);
    endtask

    // Wait for a result, compare it, then let the host accept it
    task automatic get_res(input int exp, input string name);
        int n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) begin
            chk({name, "_wait_timeout"}, 0, 1);
        end else begin
            chk(name, int'(res_data), exp);
            $display("result %s data=%0d exp=%0d at %0t", name, res_data, exp, $time);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_go(input string name);
        int n = 0;
        while (!mac_go && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mac_go) chk({name, "_go_timeout"}, 0, 1);
    endtask

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            lat;
        int            exp;
    } vec_t;

    vec_t vt[6];
    int exp_q[6];
    int g0;
    int n;
    logic [RW-1:0] held;
    int hold_err;
    int go_hold;

    initial begin
        // A*B + 2048, computed by hand
        vt[0] = '{a: 4'd3,  b: 4'd5,  lat: 1, exp: 2063};
        vt[1] = '{a: 4'd15, b: 4'd15, lat: 2, exp: 2273};
        vt[2] = '{a: 4'd0,  b: 4'd7,  lat: 5, exp: 2048};
        vt[3] = '{a: 4'd9,  b: 4'd4,  lat: 3, exp: 2084};
        vt[4] = '{a: 4'd12, b: 4'd11, lat: 8, exp: 2180};
        vt[5] = '{a: 4'd1,  b: 4'd1,  lat: 1, exp: 2049};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_go", int'(mac_go), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_data", int'(res_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_mac_a", int'(mac_a), 0);
        rst = 1'b0;

        // Single op with issue timing
        res_ready = 1'b1;
        stub_lat = 3;
        g0 = go_cnt;
        push(4'd3, 4'd5);
        @(negedge clk);
        chk("issue_go_early", int'(mac_go), 0);
        @(negedge clk);
        chk("issue_go_on_time", int'(mac_go), 1);
        chk("single_mac_a", int'(mac_a), 3);
        chk("single_mac_b", int'(mac_b), 5);
        chk("single_busy", int'(busy), 1);
        get_res(2063, "single");
        @(negedge clk);
        chk("single_valid_drop", int'(res_valid), 0);
        repeat (3) @(negedge clk);
        chk("single_go_count", go_cnt - g0, 1);

        // Table of independent ops with varying MAC latency
        for (int i = 0; i < 6; i++) begin
            stub_lat = vt[i].lat;
            g0 = go_cnt;
            push(vt[i].a, vt[i].b);
            get_res(vt[i].exp, $sformatf("vec%0d", i));
            repeat (3) @(negedge clk);
            chk($sformatf("vec%0d_go_count", i), go_cnt - g0, 1);
        end

        // Back-pressure, burst fill to full, then push while the FIFO drains
        res_ready = 1'b0;
        stub_lat = 2;
        g0 = go_cnt;
        push(4'd7, 4'd7);
        push(4'd1, 4'd2);
        push(4'd2, 4'd3);
        push(4'd4, 4'd5);
        push(4'd6, 4'd7);
        @(negedge clk);
        chk("burst_in_ready_low", int'(in_ready), 0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid", int'(res_valid), 1);
        held = res_data;
        go_hold = go_cnt;
        hold_err = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!res_valid || res_data != held) hold_err++;
        end
        chk("bp_hold_stable", hold_err, 0);
        chk("bp_no_new_go", go_cnt - go_hold, 0);
        chk("bp_full_busy", int'(busy), 1);
        exp_q = '{2097, 2050, 2054, 2068, 2090, 2120};
        fork
            push(4'd8, 4'd9);
            begin
                res_ready = 1'b1;
                for (int k = 0; k < 6; k++) get_res(exp_q[k], $sformatf("order%0d", k));
            end
        join
        repeat (3) @(negedge clk);
        chk("burst_go_count", go_cnt - g0, 6);
        chk("burst_idle", int'(busy), 0);

        // Reset while go is high: go must drop without waiting for a clock
        stub_lat = 20;
        push(4'd5, 4'd5);
        wait_go("rst_launch");
        #2 rst = 1'b1;
        #1;
        chk("rst_launch_go", int'(mac_go), 0);
        chk("rst_launch_in_ready", int'(in_ready), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset in WAIT: nothing stale may come out afterwards
        push(4'd6, 4'd6);
        wait_go("rst_wait");
        repeat (5) @(negedge clk);
        chk("rst_wait_busy_before", int'(busy), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_wait_go", int'(mac_go), 0);
        chk("rst_wait_res_valid", int'(res_valid), 0);
        chk("rst_wait_in_ready", int'(in_ready), 1);
        chk("rst_wait_busy", int'(busy), 0);
        chk("rst_wait_mac_a", int'(mac_a), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (res_valid) n++;
        end
        chk("rst_no_stale", n, 0);
        stub_lat = 2;
        g0 = go_cnt;
        push(4'd2, 4'd2);
        get_res(2052, "after_rst");
        repeat (3) @(negedge clk);
        chk("after_rst_go_count", go_cnt - g0, 1);

`ifdef MAC_DRV_TIMEOUT_EN
        // Watchdog: stub never answers
        stub_never = 1'b1;
        push(4'd3, 4'd3);
        wait_go("tmo");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!res_valid && n < 200);
        chk("tmo_latency", n, TO + 1);
        chk("tmo_res_data", int'(res_data), 0);
        chk("tmo_flag", int'(timeout), 1);
        @(posedge clk);
        #1;
        stub_never = 1'b0;
        stub_lat = 2;
        push(4'd2, 4'd5);
        get_res(2058, "tmo_next");
        chk("tmo_sticky", int'(timeout), 1);
`else
        chk("timeout_tied_low", int'(timeout), 0);
`endif

        chk("go_single_cycle", go_wide, 0);
        chk("operands_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
